intersection_controller: RTL

INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

---
 rtl/intersection_controller.sv | 122 ++++++++++++
 1 files changed

// File: rtl/intersection_controller.sv
// Two-way intersection controller with a pedestrian walk phase.
// Main street A rests on green; side street B is served on demand from the
// vehicle sensor. Pedestrian requests are latched and served only from an
// all-red clearance interval, never by cutting a green short.
module intersection_controller #(
  parameter int CLK_FREQ    = 4,
  parameter int GREEN_MIN_S = 2,
  parameter int GREEN_MAX_S = 5,
  parameter int YELLOW_S    = 1,
  parameter int ALLRED_S    = 1,
  parameter int PED_S       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic car_b,
  input  logic ped_req,
  output logic a_red,
  output logic a_yellow,
  output logic a_green,
  output logic b_red,
  output logic b_yellow,
  output logic b_green,
  output logic walk,
  output logic ped_pending
);

  localparam int GMIN   = GREEN_MIN_S * CLK_FREQ;
  localparam int GMAX   = GREEN_MAX_S * CLK_FREQ;
  localparam int YEL    = YELLOW_S * CLK_FREQ;
  localparam int ALLR   = ALLRED_S * CLK_FREQ;
  localparam int PED    = PED_S * CLK_FREQ;

  // GMAX >= GMIN, so GMIN never sets the largest duration.
  localparam int MAX_GY = (GMAX > YEL) ? GMAX : YEL;
  localparam int MAX_AP = (ALLR > PED) ? ALLR : PED;
  localparam int MAX_D  = (MAX_GY > MAX_AP) ? MAX_GY : MAX_AP;
  localparam int TW     = (MAX_D > 1) ? $clog2(MAX_D) : 1;

  // Terminal timer values: a state lasting N cycles ends when timer == N-1.
  localparam logic [TW-1:0] GMIN_T = TW'(GMIN - 1);
  localparam logic [TW-1:0] GMAX_T = TW'(GMAX - 1);
  localparam logic [TW-1:0] YEL_T  = TW'(YEL - 1);
  localparam logic [TW-1:0] ALLR_T = TW'(ALLR - 1);
  localparam logic [TW-1:0] PED_T  = TW'(PED - 1);

  typedef enum logic [2:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALLRED_AB = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALLRED_BA = 3'd5,
    WALK      = 3'd6
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [TW-1:0]   timer_q;
  logic            state_change;
  logic            enter_walk;

  assign state_change = (state_d != state_q);
  assign enter_walk   = (state_d == WALK) && (state_q != WALK);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= A_GREEN;
    else     state_q <= state_d;
  end

  // Dwell timer: restarts at every state change. It saturates instead of
  // wrapping so an arbitrarily long A_GREEN rest keeps its minimum-green credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 timer_q <= '0;
    else if (state_change)   timer_q <= '0;
    else if (timer_q != '1)  timer_q <= timer_q + TW'(1);
  end

  // Pedestrian latch: entering WALK serves the request and overrides a
  // simultaneous press; presses during WALK are already being served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              ped_pending <= 1'b0;
    else if (enter_walk)                  ped_pending <= 1'b0;
    else if (ped_req && state_q != WALK)  ped_pending <= 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      A_GREEN:   if (timer_q >= GMIN_T && (car_b || ped_pending)) state_d = A_YELLOW;
      A_YELLOW:  if (timer_q == YEL_T) state_d = ALLRED_AB;
      ALLRED_AB: if (timer_q == ALLR_T) state_d = ped_pending ? WALK : B_GREEN;
      B_GREEN:   if ((timer_q >= GMIN_T && (!car_b || ped_pending)) ||
                     timer_q == GMAX_T) state_d = B_YELLOW;
      B_YELLOW:  if (timer_q == YEL_T) state_d = ALLRED_BA;
      ALLRED_BA: if (timer_q == ALLR_T) state_d = ped_pending ? WALK : A_GREEN;
      WALK:      if (timer_q == PED_T) state_d = car_b ? B_GREEN : A_GREEN;
      default:   state_d = A_GREEN;
    endcase
  end

  // Lamp decode from the state register alone; red is the default everywhere.
  always_comb begin
    a_red    = 1'b1;
    a_yellow = 1'b0;
    a_green  = 1'b0;
    b_red    = 1'b1;
    b_yellow = 1'b0;
    b_green  = 1'b0;
    walk     = 1'b0;
    unique case (state_q)
      A_GREEN:  begin a_red = 1'b0; a_green  = 1'b1; end
      A_YELLOW: begin a_red = 1'b0; a_yellow = 1'b1; end
      B_GREEN:  begin b_red = 1'b0; b_green  = 1'b1; end
      B_YELLOW: begin b_red = 1'b0; b_yellow = 1'b1; end
      WALK:     walk = 1'b1;
      default:  ;
    endcase
  end

endmodule
